// File: rtl/am29_upc_sequencer.sv
// rtl/am29_upc_sequencer.sv - microprogram address sequencer slice with return stack
//
// Purpose: selects the next microaddress from uPC, the address register, the
// stack top or D. It can force that address to zero and drives it on y. The
// incremented address is loaded into uPC, and a push/pop return-address stack
// is kept alongside. The slice cascades through cn/cn4.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   d               direct address from the upstream mux
//   r, re_          address register data / load enable (active low)
//   s               source select: 0=uPC 1=AR 2=stack top 3=D
//   fe_, pup        stack op enable (active low) / 1=push 0=pop
//   zero_           force address to zero (active low)
//   cn, cn4         incrementer carry in / carry out
//   oe_             output enable (active low), y=0 when high
//   y               next microaddress
//   full, empty     stack occupancy flags
//   err             sticky stack overflow/underflow flag
module am29_upc_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] r,
  input  logic             re_,
  input  logic [1:0]       s,
  input  logic             fe_,
  input  logic             pup,
  input  logic             zero_,
  input  logic             cn,
  input  logic             oe_,
  output logic [WIDTH-1:0] y,
  output logic             cn4,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  logic [WIDTH-1:0] r_upc;
  logic [WIDTH-1:0] r_ar;
  logic [WIDTH-1:0] r_stk [DEPTH];
  logic [SPW-1:0]   r_sp;
  logic             r_err;

  logic             w_full;
  logic             w_empty;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_push_idx;
  logic [WIDTH-1:0] w_top;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH:0]   w_sum;

  assign w_full  = (r_sp == SPW'(DEPTH));
  assign w_empty = (r_sp == '0);

  // sp points one past the top entry; a push writes at sp, the top lives at sp-1.
  assign w_top_idx  = AW'(r_sp - SPW'(1));
  assign w_push_idx = AW'(r_sp);
  assign w_top      = w_empty ? '0 : r_stk[w_top_idx];

  always_comb begin
    w_x = r_upc;
    case (s)
      2'd0:    w_x = r_upc;
      2'd1:    w_x = r_ar;
      2'd2:    w_x = w_top;
      default: w_x = d;
    endcase
  end

  assign w_a   = zero_ ? w_x : '0;
  // Incrementer sits before the output enable so cn4 and uPC ignore oe_.
  assign w_sum = {1'b0, w_a} + {{WIDTH{1'b0}}, cn};

  assign y     = oe_ ? '0 : w_a;
  assign cn4   = w_sum[WIDTH];
  assign full  = w_full;
  assign empty = w_empty;
  assign err   = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_upc <= '0;
      r_ar  <= '0;
      r_sp  <= '0;
      r_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_stk[i] <= '0;
      end
    end else begin
      r_upc <= w_sum[WIDTH-1:0];
      if (!re_) begin
        r_ar <= r;
      end
      if (!fe_) begin
        if (pup) begin
          if (w_full) begin
            r_err <= 1'b1;
          end else begin
            // Pushes the pre-edge uPC, i.e. the return address of this cycle.
            r_stk[w_push_idx] <= r_upc;
            r_sp              <= r_sp + SPW'(1);
          end
        end else begin
          // A pop only moves sp; the stale entry is overwritten by the next push.
          if (w_empty) begin
            r_err <= 1'b1;
          end else begin
            r_sp <= r_sp - SPW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_am29_upc_sequencer.sv
// tb/tb_am29_upc_sequencer.sv - bench for am29_upc_sequencer against a queue-based model
module tb_am29_upc_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] d = '0;
  logic [3:0] r = '0;
  logic       re_ = 1'b1;
  logic [1:0] s = '0;
  logic       fe_ = 1'b1;
  logic       pup = 1'b0;
  logic       zero_ = 1'b1;
  logic       cn = 1'b0;
  logic       oe_ = 1'b0;
  logic [3:0] y;
  logic       cn4;
  logic       full;
  logic       empty;
  logic       err;

  am29_upc_sequencer #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .d(d), .r(r), .re_(re_), .s(s), .fe_(fe_),
    .pup(pup), .zero_(zero_), .cn(cn), .oe_(oe_), .y(y), .cn4(cn4),
    .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference state: plain integers and a queue whose back is the stack top.
  int m_upc = 0;
  int m_ar  = 0;
  int m_stk[$];
  bit m_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_upc = 0;
    m_ar  = 0;
    m_stk.delete();
    m_err = 0;
  endtask

  task automatic chk_outputs(input string tag);
    int x, a, ey, sum;
    case (s)
      2'd0: x = m_upc;
      2'd1: x = m_ar;
      2'd2: x = (m_stk.size() > 0) ? m_stk[$] : 0;
      default: x = int'(d);
    endcase
    a   = zero_ ? x : 0;
    ey  = oe_ ? 0 : a;
    sum = a + int'(cn);
    chk({tag, ".y"},     32'(y),     32'(ey));
    chk({tag, ".cn4"},   32'(cn4),   32'(sum / 16));
    chk({tag, ".full"},  32'(full),  32'(m_stk.size() == 4));
    chk({tag, ".empty"}, 32'(empty), 32'(m_stk.size() == 0));
    chk({tag, ".err"},   32'(err),   32'(m_err));
  endtask

  // Apply inputs, check the combinational outputs mid-cycle, clock, update model.
  task automatic step(input string tag, input logic [1:0] s_i, input logic [3:0] d_i,
                      input logic [3:0] r_i, input logic re_i, input logic fe_i,
                      input logic pup_i, input logic zero_i, input logic cn_i,
                      input logic oe_i);
    int x, a, old_upc;
    s = s_i; d = d_i; r = r_i; re_ = re_i; fe_ = fe_i; pup = pup_i;
    zero_ = zero_i; cn = cn_i; oe_ = oe_i;
    #1;
    chk_outputs(tag);
    case (s_i)
      2'd0: x = m_upc;
      2'd1: x = m_ar;
      2'd2: x = (m_stk.size() > 0) ? m_stk[$] : 0;
      default: x = int'(d_i);
    endcase
    a       = zero_i ? x : 0;
    old_upc = m_upc;
    @(posedge clk);
    m_upc = (a + int'(cn_i)) % 16;
    if (!re_i) m_ar = int'(r_i);
    if (!fe_i) begin
      if (pup_i) begin
        if (m_stk.size() < 4) m_stk.push_back(old_upc);
        else m_err = 1;
      end else begin
        if (m_stk.size() > 0) void'(m_stk.pop_back());
        else m_err = 1;
      end
    end
    #1;
  endtask

  // Reset pulse placed between clock edges.
  task automatic mid_reset(input string tag);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    chk({tag, ".empty_async"}, 32'(empty), 32'd1);
    chk({tag, ".full_async"},  32'(full),  32'd0);
    chk({tag, ".err_async"},   32'(err),   32'd0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;

    // 1: dirty the state, then reset
    for (int i = 0; i < 5; i++) step("dirty", 2'd0, 4'h0, 4'h9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step("dirty_pop", 2'd0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    s = 2'd0; zero_ = 1'b1; oe_ = 1'b0; fe_ = 1'b1; re_ = 1'b1; cn = 1'b1;
    mid_reset("t1");
    chk("t1.y_after_rst", 32'(y), 32'h0);
    step("t1.inc", 2'd0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t1.upc_is_1", 32'(y), 32'h1);

    // 2: 16-step count with wrap
    mid_reset("t2");
    for (int i = 0; i < 17; i++) step("t2.cnt", 2'd0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    // 3: D source, zero_ and oe_
    step("t3.d",    2'd3, 4'hA, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step("t3.upc",  2'd0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("t3.zero", 2'd3, 4'hA, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step("t3.upc1", 2'd0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("t3.oe",   2'd3, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step("t3.upc2", 2'd0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // 4: address register load and hold
    step("t4.load", 2'd0, 4'h0, 4'h6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("t4.ar",   2'd1, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("t4.hold", 2'd1, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // 5: fill, overflow, drain, underflow
    mid_reset("t5");
    for (int i = 0; i < 3; i++) step("t5.adv", 2'd0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("t5.push", 2'd0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      s = 2'd2; fe_ = 1'b0; pup = 1'b0; zero_ = 1'b1; oe_ = 1'b0; cn = 1'b0;
      #1;
      chk("t5.pop_const", 32'(y), 32'(6 - i));
      step("t5.pop", 2'd2, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    step("t5.under", 2'd2, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("t5.after", 2'd2, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // 6: push with s=2, then async reset at sp=3
    mid_reset("t6");
    step("t6.a",     2'd3, 4'h7, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step("t6.push1", 2'd0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step("t6.push2", 2'd2, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step("t6.push3", 2'd2, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step("t6.top",   2'd2, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    mid_reset("t6");

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [3:0] rd, rr;
      logic [1:0] rs;
      rd = 4'($urandom);
      rr = 4'($urandom);
      rs = 2'($urandom);
      step("rnd", rs, rd, rr, 1'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom),
           ($urandom_range(0, 7) != 0), 1'($urandom), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 63) == 0) mid_reset("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
